// File: rtl/mem_access_unit.sv
// Load/store sequencing stage: checks a request, strobes data memory for one
// cycle, then returns a registered writeback or exception response.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dm_mem_read,
    output logic        dm_mem_write,
    output logic [2:0]  dm_funct3,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_write_data,
    input  logic [31:0] dm_read_data,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e      state_q;
    logic        is_load_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        exc_q;
    logic [1:0]  cause_q;

    logic        rsp_valid_q;
    logic        rsp_we_q;
    logic [4:0]  rsp_rd_q;
    logic [31:0] rsp_data_q;
    logic        exc_valid_q;
    logic [1:0]  exc_cause_q;
    logic [31:0] exc_addr_q;

    logic [31:0] addr_d;
    logic [2:0]  size_d;
    logic        illegal_d;
    logic        misal_d;
    logic        fault_d;
    logic        exc_d;
    logic [1:0]  cause_d;
    logic        accept;
    logic        in_access;
    logic        good_load;

    assign addr_d = req_base + req_offset;

    always_comb begin
        size_d = 3'd4;
        unique case (req_funct3[1:0])
            2'b00:   size_d = 3'd1;
            2'b01:   size_d = 3'd2;
            default: size_d = 3'd4;
        endcase
    end

    assign illegal_d = (req_is_load & req_is_store)
                     | (req_is_load & ((req_funct3 == 3'b011)
                                     | (req_funct3 == 3'b110)
                                     | (req_funct3 == 3'b111)))
                     | (req_is_store & (req_funct3 >= 3'b011));

    assign misal_d = ((req_funct3[1:0] == 2'b01) & addr_d[0])
                   | ((req_funct3[1:0] == 2'b10) & (addr_d[1:0] != 2'b00));

    // 33-bit sum so an address that wraps past 2^32 still faults
    assign fault_d = (({1'b0, addr_d} + {30'b0, size_d}) > 33'(MEM_BYTES));

    assign exc_d = (req_is_load | req_is_store)
                 & (illegal_d | misal_d | fault_d);

    always_comb begin
        cause_d = 2'd3;
        if (illegal_d) begin
            cause_d = 2'd2;
        end else if (misal_d) begin
            cause_d = req_is_store ? 2'd1 : 2'd0;
        end
    end

    assign req_ready = !rst && (state_q != ACCESS);
    assign accept    = req_valid & req_ready;
    assign in_access = (state_q == ACCESS);
    assign good_load = is_load_q & !exc_q;

    assign dm_mem_read   = in_access & is_load_q & !exc_q & !rst;
    assign dm_mem_write  = in_access & is_store_q & !exc_q & !rst;
    assign dm_funct3     = funct3_q;
    assign dm_addr       = addr_q;
    assign dm_write_data = wdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_data  = rsp_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            exc_q       <= 1'b0;
            cause_q     <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rd_q    <= 5'd0;
            rsp_data_q  <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'd0;
            exc_addr_q  <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            exc_valid_q <= 1'b0;
            if (accept) begin
                is_load_q  <= req_is_load;
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                addr_q     <= addr_d;
                wdata_q    <= req_wdata;
                rd_q       <= req_rd;
                exc_q      <= exc_d;
                cause_q    <= cause_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) state_q <= ACCESS;
                end
                ACCESS: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_we_q    <= good_load & (rd_q != 5'd0);
                    rsp_rd_q    <= rd_q;
                    rsp_data_q  <= good_load ? dm_read_data : 32'd0;
                    exc_valid_q <= exc_q;
                    exc_cause_q <= exc_q ? cause_q : 2'd0;
                    exc_addr_q  <= exc_q ? addr_q : 32'd0;
                end
                RESP: begin
                    state_q <= accept ? ACCESS : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a byte-array memory and a
// transaction-level reference model.
module tb_mem_access_unit;

    localparam int MB = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_addr;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;
    logic        rsp_valid;
    logic        rsp_we;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base),
        .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
        .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
        .dm_funct3(dm_funct3), .dm_addr(dm_addr),
        .dm_write_data(dm_write_data), .dm_read_data(dm_read_data),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    logic [7:0] mem [MB];
    logic [7:0] ref_mem [MB];

    logic [6:0] a0, a1, a2, a3;
    assign a0 = dm_addr[6:0];
    assign a1 = a0 + 7'd1;
    assign a2 = a0 + 7'd2;
    assign a3 = a0 + 7'd3;

    always_comb begin
        dm_read_data = 32'd0;
        case (dm_funct3)
            3'd0: dm_read_data = {{24{mem[a0][7]}}, mem[a0]};
            3'd1: dm_read_data = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'd2: dm_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
            3'd4: dm_read_data = {24'd0, mem[a0]};
            3'd5: dm_read_data = {16'd0, mem[a1], mem[a0]};
            default: dm_read_data = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (dm_mem_write) begin
            mem[a0] <= dm_write_data[7:0];
            if (dm_funct3[1:0] != 2'b00) mem[a1] <= dm_write_data[15:8];
            if (dm_funct3[1:0] == 2'b10) begin
                mem[a2] <= dm_write_data[23:16];
                mem[a3] <= dm_write_data[31:24];
            end
        end
    end

    typedef struct {
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        bit          exc;
        logic [1:0]  cause;
        logic [31:0] data;
        int          acc;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] last_data;
    logic        last_we;
    logic        last_exc;
    logic [1:0]  last_cause;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3 % 4)
            0: return 1;
            1: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic void classify(input bit ld, input bit st,
            input logic [2:0] f3, input logic [31:0] addr,
            output bit exc, output logic [1:0] cause);
        int  sz = acc_size(f3);
        bit  ill = (ld && st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7))
                   || (st && f3 >= 3);
        bit  mis = (addr % sz) != 0;
        bit  flt = longint'({32'd0, addr}) + sz > MB;
        exc   = (ld || st) && (ill || mis || flt);
        cause = ill ? 2'd2 : mis ? (st ? 2'd1 : 2'd0) : 2'd3;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] addr);
        longint v = 0;
        int sz = acc_size(f3);
        for (int i = 0; i < sz; i++)
            v += longint'(ref_mem[(addr + i) % MB]) << (8 * i);
        if (f3 == 0 && v >= 128) v -= 256;
        if (f3 == 1 && v >= 32768) v -= 65536;
        return v[31:0];
    endfunction

    always begin
        rec_t r;
        int   idx;
        bit   er, ew;
        @(negedge clk);
        #2;
        er  = 0;
        ew  = 0;
        idx = -1;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
        end else begin
            foreach (q[i]) if (q[i].acc == cyc) idx = i;
        end
        if (idx >= 0) begin
            er = q[idx].ld && !q[idx].exc;
            ew = q[idx].st && !q[idx].exc;
            if (er || ew) begin
                chk("dm_addr", dm_addr, q[idx].addr);
                chk("dm_funct3", dm_funct3, q[idx].f3);
            end
            if (ew) begin
                chk("dm_wdata", dm_write_data, q[idx].wd);
                for (int i = 0; i < acc_size(q[idx].f3); i++)
                    ref_mem[(q[idx].addr + i) % MB] = q[idx].wd[8*i +: 8];
            end
            if (er) q[idx].data = ref_load(q[idx].f3, q[idx].addr);
        end
        chk("rd_strobe", dm_mem_read, er);
        chk("wr_strobe", dm_mem_write, ew);
        if (!rst && q.size() > 0 && q[0].acc + 1 == cyc) begin
            r = q.pop_front();
            er = r.ld && !r.exc;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rd", rsp_rd, r.rd);
            chk("rsp_we", rsp_we, er && r.rd != 0);
            chk("rsp_data", rsp_data, er ? r.data : 0);
            chk("exc_valid", exc_valid, r.exc);
            chk("exc_addr", exc_addr, r.exc ? r.addr : 0);
            if (r.exc) chk("exc_cause", exc_cause, r.cause);
            last_data  = rsp_data;
            last_we    = rsp_we;
            last_exc   = exc_valid;
            last_cause = exc_cause;
        end else begin
            chk("rsp_idle", rsp_valid, 0);
        end
    end

    task automatic send(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input bit keep);
        rec_t r;
        int   n = 0;
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = st;
        req_funct3   = f3;
        req_base     = base;
        req_offset   = off;
        req_wdata    = wd;
        req_rd       = rd;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        r.ld   = ld;
        r.st   = st;
        r.f3   = f3;
        r.addr = base + off;
        r.wd   = wd;
        r.rd   = rd;
        r.data = 32'd0;
        r.acc  = cyc + 1;
        classify(ld, st, f3, r.addr, r.exc, r.cause);
        q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #3;
    endtask

    initial begin
        logic [31:0] old8;
        int legal_f3[5] = '{0, 1, 2, 4, 5};
        for (int i = 0; i < MB; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b1;
        req_valid = 1'b0;
        req_is_load = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'd0;
        req_base = 32'd0;
        req_offset = 32'd0;
        req_wdata = 32'd0;
        req_rd = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_addr", dm_addr, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_exc", {exc_valid, exc_cause}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);

        send(0, 1, 3'd2, 32'h10, 32'h4, 32'hDEADBEEF, 5'd0, 0);
        settle();
        send(1, 0, 3'd2, 32'h14, 32'h0, 32'h0, 5'd5, 0);
        settle();
        chk("ld14_data", last_data, 32'hDEADBEEF);
        chk("ld14_we", last_we, 1);

        send(1, 0, 3'd2, 32'h20, 32'h2, 32'h0, 5'd1, 0);
        settle();
        chk("mis_ld_cause", {last_exc, last_cause}, {1'b1, 2'd0});
        send(0, 1, 3'd1, 32'h21, 32'h0, 32'h1234, 5'd0, 0);
        send(1, 0, 3'd3, 32'h0, 32'h0, 32'h0, 5'd2, 0);
        send(1, 0, 3'd2, 32'h7C, 32'h0, 32'h0, 5'd3, 0);
        send(1, 0, 3'd2, 32'h80, 32'h0, 32'h0, 5'd3, 0);
        settle();
        chk("fault_cause", {last_exc, last_cause}, {1'b1, 2'd3});
        send(1, 0, 3'd2, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd4, 0);
        send(0, 0, 3'd2, 32'h40, 32'h0, 32'h0, 5'd6, 0);

        for (int i = 0; i < 4; i++)
            send(1, 0, 3'd2, 32'h40, 32'(4 * i), 32'h0, 5'(7 + i), i < 3);

        send(0, 1, 3'd0, 32'h3, 32'h0, 32'h80, 5'd0, 0);
        send(1, 0, 3'd4, 32'h3, 32'h0, 32'h0, 5'd0, 0);
        settle();
        chk("lbu_data", last_data, 32'h80);
        chk("lbu_we", last_we, 0);

        for (int i = 0; i < 300; i++) begin
            int  k = $urandom_range(0, 9);
            bit  ld = (k == 0) || (k >= 2 && k < 6);
            bit  st = (k == 0) || k >= 6;
            logic [2:0] f3 = ($urandom_range(0, 4) != 0)
                ? 3'(legal_f3[$urandom_range(0, 4)]) : 3'($urandom_range(0, 7));
            logic [31:0] base = ($urandom_range(0, 15) == 0)
                ? $urandom : 32'($urandom_range(0, 136));
            logic [31:0] off = 32'($urandom_range(0, 16)) - 32'd8;
            send(ld, st, f3, base, off, $urandom, 5'($urandom), i < 299 &&
                 $urandom_range(0, 1) == 1);
        end
        settle();
        settle();

        old8 = {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]};
        send(0, 1, 3'd2, 32'h8, 32'h0, ~old8, 5'd0, 0);
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_in_access_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst2", req_ready, 1);
        chk("mem8_unchanged", {mem[11], mem[10], mem[9], mem[8]}, old8);
        repeat (3) @(negedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencing stage between the execute stage and the data memory. It accepts one memory request at a time over a valid/ready handshake and computes the effective address. Before any access is issued it checks the request for misalignment, illegal width encodings and out-of-range addresses. It drives the data memory's read/write strobes for exactly one cycle, then returns a registered writeback response or an exception record to the pipeline.

## Interface
Parameters:
- MEM_BYTES, 128: addressable data memory size in bytes; an effective address with addr + access_size > MEM_BYTES faults.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_is_load  in  1  request is a load.
- req_is_store  in  1  request is a store.
- req_funct3  in  3  RISC-V width/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_base  in  32  rs1 value.
- req_offset  in  32  sign-extended immediate.
- req_wdata  in  32  rs2 value (store data).
- req_rd  in  5  destination register.
- dm_mem_read  out  1  data memory read strobe.
- dm_mem_write  out  1  data memory write strobe.
- dm_funct3  out  3  width to data memory.
- dm_addr  out  32  byte address to data memory.
- dm_write_data  out  32  store data, unshifted (the memory selects lanes by address offset).
- dm_read_data  in  32  combinational, already-extended load data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_we  out  1  writeback enable.
- rsp_rd  out  5  writeback register.
- rsp_data  out  32  writeback value.
- exc_valid  out  1  exception accompanies this response.
- exc_cause  out  2  0 load misaligned, 1 store misaligned, 2 illegal, 3 access fault.
- exc_addr  out  32  faulting effective address.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset enters IDLE.
- req_ready = 1 in IDLE and in RESP, and 0 in ACCESS and whenever rst = 1.
- Acceptance: req_valid & req_ready at a rising edge.
  - Latch the request and compute addr = req_base + req_offset (mod 2^32).
  - Latch the check result.
  - Move to ACCESS.
- ACCESS always lasts one cycle, then moves to RESP.
- RESP lasts one cycle. If a new request is accepted in RESP, the next state is ACCESS; otherwise it is IDLE.
- Check priority (first match wins):
  1. Illegal (cause 2): both is_load and is_store set; load funct3 in {011, 110, 111}; store funct3 ≥ 011.
  2. Misaligned (cause 0 for loads, 1 for stores): halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
  3. Access fault (cause 3): addr + size > MEM_BYTES, where size is 1, 2 or 4. The comparison is done with 33-bit arithmetic so a wrapped address faults.
- Neither is_load nor is_store set: treated as a no-op. The request is accepted, no strobe is raised, and the response has rsp_we = 0 and exc_valid = 0.
- Memory strobes, in ACCESS only:
  - dm_mem_read = is_load & no exception & !rst.
  - dm_mem_write = is_store & no exception & !rst.
  - dm_addr, dm_funct3 and dm_write_data are driven from the latched request in every state; they are 0 after reset.
- Response registers are updated at the end of ACCESS and are visible in RESP:
  - rsp_data = dm_read_data for a good load; 0 otherwise.
  - rsp_we = good load & rd ≠ 0.
  - rsp_rd = latched rd.
  - exc_valid and exc_addr come from the latched check; exc_addr = 0 when there is no exception.
- A faulting request never raises a memory strobe.

## Timing
- Request accepted at edge N: strobes are high in cycle N+1, and a store commits at edge N+2. rsp_valid is high in cycle N+2 (2-cycle latency).
- Throughput: one request per 2 cycles with back-to-back requests (accept in RESP).
- Reset values: all outputs 0 (req_ready = 0 while rst = 1, then 1 from the first cycle after rst falls); state IDLE.
- Reset asserted during ACCESS:
  - The strobes are gated low in that same cycle, so no store commits.
  - The in-flight request is dropped and no rsp_valid is produced.
- rsp_valid is a one-cycle pulse with no backpressure; the consumer must take it.

## Test plan
- Good word store then load: store wdata = 0xDEADBEEF at base 0x10, offset 0x4. The write strobe is high for exactly one cycle. A load of word 0x14 with rd = 5 then gives rsp_valid 2 cycles after acceptance, rsp_data = 0xDEADBEEF and rsp_we = 1.
- Misaligned: load word at 0x22 → exc_valid = 1, cause 0, exc_addr = 0x22, no strobe. Store half at 0x21 → cause 1.
- Illegal and fault:
  - Load funct3 = 011 → cause 2.
  - Word load at 0x7C with MEM_BYTES = 128 → passes.
  - Word load at 0x80 → cause 3.
  - base = 0xFFFFFFFC, offset = 8 (wraps to 0x4) → passes, addr = 0x4.
- Back-to-back: hold req_valid high for 4 requests → accepts on alternate edges; 4 rsp_valid pulses at 2-cycle spacing in order.
- rd = 0 load of LBU at 0x3 with byte 0x80 → rsp_data = 0x00000080, rsp_we = 0.
- Reset during ACCESS of a store to 0x8 → memory word at 0x8 is unchanged, no rsp_valid, and req_ready = 1 in the first cycle after rst falls.
